neuron_mac: RTL and testbench
=============================

# neuron_mac

Time-multiplexed, parametrised perceptron neuron: one signed multiplier serially accumulates NUM input×weight products plus a bias, then applies a runtime-selectable activation and saturates to WIDTH bits. It generalises the combinational two-input perceptron with stored weights, a valid/ready stream interface, selectable activation and overflow flagging. It is the building block for the layer/array logic of the ANN datapath.

## Interface
- NUM, 2: number of inputs/weights per neuron (≥1)
- WIDTH, 32: signed fixed-point word width
- FRAC, 24: fractional bits (Q(WIDTH-FRAC).FRAC; default Q8.24, 1.0 = 0x01000000)

- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- wr  in  1  weight/bias load strobe
- i_w  in  NUM*WIDTH  weights, w[j] = i_w[j*WIDTH +: WIDTH]
- i_b  in  WIDTH  bias
- i_valid  in  1  input vector valid
- o_ready  out  1  block can accept a vector
- i_k  in  NUM*WIDTH  inputs, k[j] = i_k[j*WIDTH +: WIDTH]
- i_act  in  2  activation: 0 identity, 1 ReLU, 2 hard-sigmoid, 3 step
- o_valid  out  1  result valid
- i_ready  in  1  downstream accepts result
- o  out  WIDTH  activated result
- o_sat  out  1  saturation occurred while producing o

## Operation
- FSM states IDLE, MAC, ACT, DONE. Reset → IDLE.
- IDLE: o_ready=1. wr=1 loads all NUM weights and bias into internal registers (accepted only in IDLE; ignored elsewhere). i_valid&&o_ready: capture i_k and i_act, acc ← sign-extended bias << FRAC, idx ← 0, → MAC. wr and i_valid same cycle: weights load first, vector uses new weights.
- MAC: each cycle acc ← acc + k[idx]*w[idx] (full 2*WIDTH signed product), idx++; after idx = NUM-1 → ACT.
- Accumulator width 2*WIDTH + clog2(NUM+1); never overflows internally.
- ACT: z = acc >>> FRAC (arithmetic shift, truncation toward −∞), saturated to [−2^(WIDTH-1), 2^(WIDTH-1)−1]; o_sat set if clamped. Activation on saturated z:
  - identity: z
  - ReLU: max(z, 0)
  - hard-sigmoid: clamp((z >>> 2) + (1<<(FRAC-1)), 0, 1<<FRAC)
  - step: z ≥ 0 ? 1<<FRAC : 0
- Register o and o_sat, o_valid ← 1, → DONE.
- DONE: hold o, o_sat, o_valid stable; o_ready=0. On i_ready: o_valid ← 0, → IDLE.

## Timing
- Reset values: o=0, o_sat=0, o_valid=0, o_ready=1 (IDLE), weights/bias/acc=0.
- Accept edge E0; MAC edges E1..E_NUM; ACT edge E_NUM+1 makes o_valid high. Latency NUM+1 cycles from accept to o_valid.
- Handoff edge (o_valid&&i_ready) returns to IDLE; next accept possible one cycle later. Minimum period NUM+3 cycles per result.
- o_ready is a pure function of state (no combinational path from i_valid/i_ready).
- rst_n low at any time aborts the operation immediately: all state to reset values, partial sum discarded, loaded weights cleared.

## Structure
- Package neuron_pkg: act-mode enum (ACT_ID, ACT_RELU, ACT_HSIG, ACT_STEP), FSM state enum, saturate function parameterised by widths.
- Sub-module neuron_act: combinational shift/saturate/activation (inputs acc, mode; outputs result, sat), instantiated once in the ACT stage.

## Test plan
- NUM=2, Q8.24: load w={1.0,0.5}=0x01000000,0x00800000, b=0.25=0x00400000; k={2.0,1.0}, identity → o=0x02C00000 (2.75), o_sat=0, o_valid exactly 3 cycles after accept.
- Same weights, k={−3.0,1.0}: identity → 0xFDC00000 (−2.25); ReLU → 0x00000000; step → 0; hard-sigmoid → 0 (clamped).
- k={2.0,1.0}, hard-sigmoid → 0x01000000; weights/bias 0, hard-sigmoid → 0x00800000; step with z=0 → 0x01000000.
- w0=100.0 (0x64000000), k0=100.0, rest 0, identity → o=0x7FFFFFFF, o_sat=1; negated k0 → 0x80000000, o_sat=1.
- Backpressure: hold i_ready=0 for 5 cycles in DONE → o/o_valid stable, o_ready=0, wr and i_valid ignored; release → o_valid drops next cycle, o_ready rises.
- Assert rst_n low during MAC → o_valid=0, o=0, o_ready=1 immediately; after release, reloaded weights and new vector give correct result.

Source files
------------

// File: rtl/neuron_pkg.sv
// Shared types and helpers for the serial perceptron neuron.
// Latency: n/a (types and a combinational function only).
// Backpressure: n/a.
package neuron_pkg;

    // Activation selector, encoded exactly as the i_act input.
    typedef enum logic [1:0] {
        ACT_ID   = 2'd0,
        ACT_RELU = 2'd1,
        ACT_HSIG = 2'd2,
        ACT_STEP = 2'd3
    } act_e;

    // Neuron sequencing states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        ACT  = 2'd2,
        DONE = 2'd3
    } state_e;

    // Widest value the saturate helper can take; the accumulator must fit.
    localparam int SAT_MAXW = 192;

    // Clamp a signed value to the signed range of an out_w-bit word.
    // The result stays sign-extended to SAT_MAXW; callers keep the low out_w bits.
    function automatic logic signed [SAT_MAXW-1:0] saturate(
        input  logic signed [SAT_MAXW-1:0] v,
        input  int unsigned                out_w,
        output logic                       clamped
    );
        logic signed [SAT_MAXW-1:0] hi;
        logic signed [SAT_MAXW-1:0] lo;
        hi = ({{(SAT_MAXW-1){1'b0}}, 1'b1} <<< (out_w - 1)) - {{(SAT_MAXW-1){1'b0}}, 1'b1};
        lo = ~hi;
        clamped = 1'b0;
        saturate = v;
        if (v > hi) begin
            saturate = hi;
            clamped  = 1'b1;
        end else if (v < lo) begin
            saturate = lo;
            clamped  = 1'b1;
        end
    endfunction

endpackage

// File: rtl/neuron_mac_if.sv
// Stream and weight-load bundle between a neuron and its driver.
// Latency: n/a (wiring only).
// Backpressure: i_valid/o_ready on the input side, o_valid/i_ready on the result side.
interface neuron_mac_if #(
    parameter int NUM   = 2,
    parameter int WIDTH = 32
);
    logic                   wr;
    logic [NUM*WIDTH-1:0]   i_w;
    logic [WIDTH-1:0]       i_b;
    logic                   i_valid;
    logic                   o_ready;
    logic [NUM*WIDTH-1:0]   i_k;
    logic [1:0]             i_act;
    logic                   o_valid;
    logic                   i_ready;
    logic [WIDTH-1:0]       o;
    logic                   o_sat;

    modport master (
        output wr, i_w, i_b, i_valid, i_k, i_act, i_ready,
        input  o_ready, o_valid, o, o_sat
    );

    modport slave (
        input  wr, i_w, i_b, i_valid, i_k, i_act, i_ready,
        output o_ready, o_valid, o, o_sat
    );
endinterface

// File: rtl/neuron_act.sv
// Rescale the accumulator to WIDTH bits with saturation, then apply the activation.
// Latency: combinational.
// Backpressure: none; the caller registers the result.
module neuron_act
    import neuron_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int FRAC  = 24,
    parameter int ACCW  = 66
) (
    input  logic signed [ACCW-1:0] acc,
    input  act_e                   mode,
    output logic [WIDTH-1:0]       result,
    output logic                   sat
);
    // 1.0 and 0.5 in the output format; one extra bit keeps the hard-sigmoid sum from wrapping.
    localparam logic signed [WIDTH:0] ONE_X  = {{WIDTH{1'b0}}, 1'b1} << FRAC;
    localparam logic signed [WIDTH:0] HALF_X = {{WIDTH{1'b0}}, 1'b1} << (FRAC - 1);
    localparam logic [WIDTH-1:0]      ONE_W  = ONE_X[WIDTH-1:0];

    logic signed [ACCW-1:0]     shifted;
    logic signed [SAT_MAXW-1:0] z_wide;
    logic signed [WIDTH-1:0]    z;
    logic signed [WIDTH:0]      hs;

    // Floor-shift, clamp to WIDTH bits, then select the activation.
    always_comb begin
        shifted = acc >>> FRAC;
        z_wide  = saturate(SAT_MAXW'(shifted), WIDTH, sat);
        z       = z_wide[WIDTH-1:0];
        hs      = ($signed({z[WIDTH-1], z}) >>> 2) + HALF_X;
        result  = z;
        case (mode)
            ACT_ID:   result = z;
            ACT_RELU: result = z[WIDTH-1] ? '0 : z;
            ACT_HSIG: begin
                if (hs < 0)          result = '0;
                else if (hs > ONE_X) result = ONE_W;
                else                 result = hs[WIDTH-1:0];
            end
            ACT_STEP: result = z[WIDTH-1] ? '0 : ONE_W;
            default:  result = z;
        endcase
    end
endmodule

// File: rtl/neuron_mac.sv
// Serial perceptron: bias plus NUM input*weight products through one multiplier, then activation.
// Latency: NUM+1 cycles from accept to o_valid; one result per NUM+3 cycles at best.
// Backpressure: o_ready only in IDLE; result held stable in DONE until i_ready.
module neuron_mac
    import neuron_pkg::*;
#(
    parameter int NUM   = 2,
    parameter int WIDTH = 32,
    parameter int FRAC  = 24
) (
    input  logic         clk,
    input  logic         rst_n,
    neuron_mac_if.slave  bus
);
    // Wide enough that NUM full products plus the bias can never overflow.
    localparam int ACCW = 2*WIDTH + $clog2(NUM + 1);
    localparam int IDXW = (NUM > 1) ? $clog2(NUM) : 1;

    state_e                     state;
    logic [NUM-1:0][WIDTH-1:0]  w_reg;
    logic [NUM-1:0][WIDTH-1:0]  k_reg;
    logic [WIDTH-1:0]           b_reg;
    act_e                       act_reg;
    logic signed [ACCW-1:0]     acc;
    logic [IDXW-1:0]            idx;
    logic [WIDTH-1:0]           bias_sel;
    logic signed [2*WIDTH-1:0]  prod;
    logic [WIDTH-1:0]           act_res;
    logic                       act_sat;

    // A load in the accept cycle takes effect for that same vector.
    assign bias_sel = bus.wr ? bus.i_b : b_reg;

    // Full-width signed product of the current input/weight pair.
    assign prod = (2*WIDTH)'($signed(k_reg[idx])) * (2*WIDTH)'($signed(w_reg[idx]));

    // Readiness depends on state only.
    assign bus.o_ready = (state == IDLE);

    neuron_act #(
        .WIDTH (WIDTH),
        .FRAC  (FRAC),
        .ACCW  (ACCW)
    ) u_act (
        .acc    (acc),
        .mode   (act_reg),
        .result (act_res),
        .sat    (act_sat)
    );

    // Sequencer: load/accept, serial accumulate, activate, hold until taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            w_reg       <= '0;
            k_reg       <= '0;
            b_reg       <= '0;
            act_reg     <= ACT_ID;
            acc         <= '0;
            idx         <= '0;
            bus.o       <= '0;
            bus.o_sat   <= 1'b0;
            bus.o_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.wr) begin
                        w_reg <= bus.i_w;
                        b_reg <= bus.i_b;
                    end
                    if (bus.i_valid) begin
                        k_reg   <= bus.i_k;
                        act_reg <= act_e'(bus.i_act);
                        acc     <= ACCW'($signed(bias_sel)) <<< FRAC;
                        idx     <= '0;
                        state   <= MAC;
                    end
                end
                MAC: begin
                    acc <= acc + ACCW'(prod);
                    if (idx == IDXW'(NUM - 1)) begin
                        state <= ACT;
                    end else begin
                        idx <= idx + IDXW'(1);
                    end
                end
                ACT: begin
                    bus.o       <= act_res;
                    bus.o_sat   <= act_sat;
                    bus.o_valid <= 1'b1;
                    state       <= DONE;
                end
                DONE: begin
                    if (bus.i_ready) begin
                        bus.o_valid <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_neuron_mac.sv
// Directed bench for neuron_mac: expected results queued at issue, checked by a monitor on handoff.
// Latency: checks NUM+1 cycles from accept to o_valid on every vector.
// Backpressure: exercises a held result with i_ready low and writes/vectors that must be ignored.
module tb_neuron_mac;
    import neuron_pkg::*;

    localparam int NUM   = 2;
    localparam int WIDTH = 32;
    localparam int FRAC  = 24;

    localparam logic [WIDTH-1:0] Q_ONE  = 32'h0100_0000;
    localparam logic [WIDTH-1:0] Q_HALF = 32'h0080_0000;
    localparam logic [WIDTH-1:0] Q_QTR  = 32'h0040_0000;
    localparam logic [WIDTH-1:0] Q_TWO  = 32'h0200_0000;
    localparam logic [WIDTH-1:0] Q_M3   = 32'hFD00_0000;
    localparam logic [WIDTH-1:0] Q_100  = 32'h6400_0000;
    localparam logic [WIDTH-1:0] Q_M100 = 32'h9C00_0000;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    neuron_mac_if #(.NUM(NUM), .WIDTH(WIDTH)) bus ();

    neuron_mac #(.NUM(NUM), .WIDTH(WIDTH), .FRAC(FRAC)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int n_tests = 0;
    int n_fail  = 0;
    logic [WIDTH:0] exp_q [$];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, got, want, $time);
        end
    endtask

    // Monitor: on every handoff compare against the oldest queued expectation.
    initial begin
        logic [WIDTH:0] e;
        forever begin
            @(negedge clk);
            #1;
            if (rst_n === 1'b1 && bus.o_valid === 1'b1 && bus.i_ready === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_result", 64'd1, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("o", 64'(bus.o), 64'(e[WIDTH-1:0]));
                    check("o_sat", 64'(bus.o_sat), 64'(e[WIDTH]));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic load(input logic [WIDTH-1:0] w0, input logic [WIDTH-1:0] w1, input logic [WIDTH-1:0] b);
        @(negedge clk);
        bus.wr  = 1'b1;
        bus.i_w = {w1, w0};
        bus.i_b = b;
        @(negedge clk);
        bus.wr  = 1'b0;
    endtask

    // Wait for o_ready, present one vector (optionally with a same-cycle load), queue its expectation.
    task automatic issue(input logic [WIDTH-1:0] k0, input logic [WIDTH-1:0] k1, input logic [1:0] act,
                         input logic [WIDTH-1:0] exp_o, input logic exp_sat, input bit push,
                         input bit do_wr, input logic [WIDTH-1:0] w0, input logic [WIDTH-1:0] w1,
                         input logic [WIDTH-1:0] b);
        int t = 0;
        @(negedge clk);
        while (bus.o_ready !== 1'b1 && t < 20) begin
            @(negedge clk);
            t++;
        end
        check("ready_wait", 64'(bus.o_ready), 64'd1);
        bus.i_valid = 1'b1;
        bus.i_k     = {k1, k0};
        bus.i_act   = act;
        if (do_wr) begin
            bus.wr  = 1'b1;
            bus.i_w = {w1, w0};
            bus.i_b = b;
        end
        if (push) exp_q.push_back({exp_sat, exp_o});
        @(negedge clk);
        bus.i_valid = 1'b0;
        bus.wr      = 1'b0;
    endtask

    // Count edges after the accept edge until o_valid appears.
    task automatic wait_result();
        int cyc = 0;
        while (bus.o_valid !== 1'b1 && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check("latency", 64'(cyc), 64'(NUM + 1));
    endtask

    task automatic run_vec(input logic [WIDTH-1:0] k0, input logic [WIDTH-1:0] k1, input logic [1:0] act,
                           input logic [WIDTH-1:0] exp_o, input logic exp_sat);
        issue(k0, k1, act, exp_o, exp_sat, 1'b1, 1'b0, '0, '0, '0);
        wait_result();
    endtask

    initial begin
        bus.wr      = 1'b0;
        bus.i_w     = '0;
        bus.i_b     = '0;
        bus.i_valid = 1'b0;
        bus.i_k     = '0;
        bus.i_act   = 2'd0;
        bus.i_ready = 1'b1;
        rst_n       = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_o", 64'(bus.o), 64'd0);
        check("rst_o_sat", 64'(bus.o_sat), 64'd0);
        check("rst_o_valid", 64'(bus.o_valid), 64'd0);
        check("rst_o_ready", 64'(bus.o_ready), 64'd1);
        rst_n = 1'b1;

        // Basic weighted sums with each activation.
        load(Q_ONE, Q_HALF, Q_QTR);
        run_vec(Q_TWO, Q_ONE, 2'd0, 32'h02C0_0000, 1'b0);
        run_vec(Q_M3,  Q_ONE, 2'd0, 32'hFDC0_0000, 1'b0);
        run_vec(Q_M3,  Q_ONE, 2'd1, 32'h0000_0000, 1'b0);
        run_vec(Q_M3,  Q_ONE, 2'd3, 32'h0000_0000, 1'b0);
        run_vec(Q_M3,  Q_ONE, 2'd2, 32'h0000_0000, 1'b0);
        run_vec(Q_TWO, Q_ONE, 2'd2, 32'h0100_0000, 1'b0);
        run_vec(Q_TWO, Q_ONE, 2'd1, 32'h02C0_0000, 1'b0);

        // z = 0: hard-sigmoid midpoint and step threshold.
        load('0, '0, '0);
        run_vec(Q_TWO, Q_ONE, 2'd2, 32'h0080_0000, 1'b0);
        run_vec(Q_TWO, Q_ONE, 2'd3, 32'h0100_0000, 1'b0);

        // Saturation at both rails.
        load(Q_100, '0, '0);
        run_vec(Q_100,  '0, 2'd0, 32'h7FFF_FFFF, 1'b1);
        run_vec(Q_M100, '0, 2'd0, 32'h8000_0000, 1'b1);

        // Load and vector in the same cycle: new weights and bias apply (0.5*2 + 0.5*1 + 0.25).
        issue(Q_TWO, Q_ONE, 2'd0, 32'h01C0_0000, 1'b0, 1'b1, 1'b1, Q_HALF, Q_HALF, Q_QTR);
        wait_result();

        // Backpressure: result held, writes and vectors ignored while in DONE.
        load(Q_ONE, Q_HALF, Q_QTR);
        bus.i_ready = 1'b0;
        issue(Q_TWO, Q_ONE, 2'd0, 32'h02C0_0000, 1'b0, 1'b1, 1'b0, '0, '0, '0);
        wait_result();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            bus.wr      = 1'b1;
            bus.i_w     = '0;
            bus.i_b     = '0;
            bus.i_valid = 1'b1;
            bus.i_k     = {Q_M3, Q_M3};
            check("hold_o", 64'(bus.o), 64'h02C0_0000);
            check("hold_o_valid", 64'(bus.o_valid), 64'd1);
            check("hold_o_ready", 64'(bus.o_ready), 64'd0);
        end
        @(negedge clk);
        bus.wr      = 1'b0;
        bus.i_valid = 1'b0;
        bus.i_ready = 1'b1;
        @(negedge clk);
        check("release_o_valid", 64'(bus.o_valid), 64'd0);
        check("release_o_ready", 64'(bus.o_ready), 64'd1);
        run_vec(Q_TWO, Q_ONE, 2'd0, 32'h02C0_0000, 1'b0);

        // Reset in the middle of MAC: immediate abort, weights cleared.
        issue(Q_TWO, Q_ONE, 2'd0, '0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
        rst_n = 1'b0;
        #1;
        check("abort_o_valid", 64'(bus.o_valid), 64'd0);
        check("abort_o", 64'(bus.o), 64'd0);
        check("abort_o_ready", 64'(bus.o_ready), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        run_vec(Q_TWO, Q_ONE, 2'd0, 32'h0000_0000, 1'b0);
        load(Q_ONE, Q_HALF, Q_QTR);
        run_vec(Q_TWO, Q_ONE, 2'd0, 32'h02C0_0000, 1'b0);

        repeat (3) @(negedge clk);
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
